// File: rtl/seq_detect_moore_param.sv
// Runtime-programmable Moore serial-pattern detector with overlap/non-overlap modes.
// Optional saturating match counter is compiled in when SEQDET_COUNT_EN is defined.
module seq_detect_moore_param #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_0101,
  parameter int unsigned          DEF_LEN     = 3,
  parameter bit                   DEF_OVERLAP = 1'b1,
  parameter int unsigned          CNT_W       = 8,
  localparam int unsigned         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               detect,
  output logic [LW-1:0]      state_o,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam int unsigned     IW      = $clog2(MAX_LEN);
  localparam logic [LW:0]     MaxLenW = (LW + 1)'(MAX_LEN);
  localparam logic [LW-1:0]   DefLen  = LW'(DEF_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  // Only MAX_LEN-1 past bits are needed; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      state_q, state_d;
  logic               detect_q, detect_d;
  logic               err_q, err_d;

  logic               cfg_ok;
  logic               cfg_accept;
  logic [MAX_LEN-1:0] cfg_mask;

  logic [MAX_LEN-1:0] hist_shift;
  logic [LW-1:0]      eff_state;
  logic [LW-1:0]      lim;
  logic [LW-1:0]      next_state;
  logic [LW-1:0]      idx;
  logic               prefix_ok;

  assign cfg_ok     = (cfg_len != '0) && ({1'b0, cfg_len} <= MaxLenW);
  assign cfg_accept = cfg_load && cfg_ok;

  always_comb begin
    cfg_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      cfg_mask[i[IW-1:0]] = (LW'(i) < cfg_len);
    end
  end

  // Longest pattern prefix that is a suffix of the history including the new bit.
  always_comb begin
    hist_shift = {hist_q, din};
    eff_state  = state_q;
    if (!ovl_q && (state_q == len_q)) begin
      hist_shift = {{(MAX_LEN - 1){1'b0}}, din};
      eff_state  = '0;
    end
    lim        = (eff_state == len_q) ? len_q : eff_state + 1'b1;
    next_state = '0;
    idx        = '0;
    prefix_ok  = 1'b0;
    for (int k = 1; k <= int'(MAX_LEN); k++) begin
      if (LW'(k) <= lim) begin
        prefix_ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          idx = len_q - LW'(k) + LW'(i);
          if (hist_shift[i[IW-1:0]] != pat_q[idx[IW-1:0]]) begin
            prefix_ok = 1'b0;
          end
        end
        if (prefix_ok) begin
          next_state = LW'(k);
        end
      end
    end
  end

  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    state_d  = state_q;
    detect_d = detect_q;
    err_d    = 1'b0;
    if (cfg_accept) begin
      pat_d    = cfg_pattern & cfg_mask;
      len_d    = cfg_len;
      ovl_d    = cfg_overlap;
      hist_d   = '0;
      state_d  = '0;
      detect_d = 1'b0;
    end else begin
      err_d = cfg_load;
      if (din_valid) begin
        hist_d   = hist_shift[MAX_LEN-2:0];
        state_d  = next_state;
        detect_d = (next_state == len_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q    <= DEF_PATTERN;
      len_q    <= DefLen;
      ovl_q    <= DEF_OVERLAP;
      hist_q   <= '0;
      state_q  <= '0;
      detect_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      hist_q   <= hist_d;
      state_q  <= state_d;
      detect_q <= detect_d;
      err_q    <= err_d;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  always_comb begin
    cnt_d = cnt_q;
    hit   = din_valid && !cfg_accept && (next_state == len_q);
    if (cfg_accept) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

  assign detect  = detect_q;
  assign state_o = state_q;
  assign cfg_err = err_q;

endmodule

// File: doc/seq_detect_moore_param.md
Name: seq_detect_moore_param

Overview:
- Parametrised, runtime-programmable Moore serial-pattern detector. Successor to the fixed "101" Moore detector.
- Consumes one qualified bit per cycle and tracks the longest matched pattern prefix as its FSM state. Asserts a registered detect flag when the full pattern has been matched.
- Supports pattern lengths 1..MAX_LEN, overlapping or non-overlapping detection, and a match counter.
- Sits behind the sequence-detector interface and is driven by the program-block testbench.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- DEF_PATTERN, 8'b0000_0101, reset pattern value, right-aligned in MAX_LEN bits.
- DEF_LEN, 3, reset pattern length.
- DEF_OVERLAP, 1, reset overlap mode (1 = overlapping).
- CNT_W, 8, match counter width.
- LW = $clog2(MAX_LEN+1), derived, width of length and state fields.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- din_valid  in  1  din is sampled this cycle.
- din  in  1  serial data bit.
- cfg_load  in  1  one-cycle request to load a new configuration.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned. Bit [cfg_len-1] is matched first.
- cfg_len  in  LW  new pattern length.
- cfg_overlap  in  1  new overlap mode.
- detect  out  1  Moore output: high while state == active length.
- state_o  out  LW  current matched-prefix length (debug/visibility).
- match_count  out  CNT_W  number of completed matches, saturating.
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - state = 0, detect = 0, match_count = 0, cfg_err = 0.
  - Active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
  - The history register is cleared.
- State meaning: state k = the last k accepted bits since the last restart equal the first k pattern bits, with k maximal. Range is 0..len.
- Pattern order: the first bit received is compared with pattern[len-1]; the last bit received is compared with pattern[0].
- Cycle with din_valid=1 and no cfg_load:
  - The bit is shifted into the history register.
  - Next state = largest k in 1..min(state+1, len) whose history suffix equals the pattern prefix of length k; 0 if none.
- Non-overlap mode: when state == len, the next accepted bit restarts matching from empty history. Next state = 1 if din == pattern[len-1], else 0.
- Overlap mode: the next-state rule applies unchanged from state == len, so matched bits may begin a new match.
- Cycle with din_valid=0: state, history and detect hold.
  - detect therefore stays high across valid gaps until the next accepted bit.
- detect is registered: it equals (state == len) and rises the cycle after the final pattern bit is sampled. Latency is 1 cycle. Never combinational from din.
- match_count:
  - Increments by 1 on every transition into state == len, including len→len in overlap mode.
  - Saturates at all-ones; no wrap.
- cfg_load handling:
  - Accepted when 1 <= cfg_len <= MAX_LEN. The new config takes effect next cycle.
  - On acceptance: state = 0, history cleared, detect = 0, match_count = 0.
  - A din_valid bit in the same cycle as cfg_load is discarded.
  - Pattern bits above cfg_len-1 are ignored.
  - If cfg_len is 0 or > MAX_LEN: the config is unchanged, the FSM continues normally with din processed, and cfg_err pulses high for exactly one cycle.
- len = 1: state toggles between 0 and 1. Non-overlap and overlap behave identically.
- Reset mid-operation: all state is dropped immediately and the config reverts to defaults. Partial matches are lost.

Optional Feature:
- Macro: SEQDET_COUNT_EN.
- Defined: match_count behaves as specified.
- Undefined: the counter logic is not compiled; match_count is tied to 0. All other behaviour is identical.

Test Plan:
1. Reset defaults (101, overlap), bits 1,0,1,0,1 on consecutive cycles:
   - detect is high the cycle after the 3rd bit, low after the 4th, and high again after the 5th.
   - match_count = 2.
2. cfg_load with pattern 101, len 3, overlap 0, then bits 1,0,1,0,1,1,0,1:
   - detect is high after bit 3 and after bit 8 only.
   - match_count = 2.
3. Defaults, bits 1,0,1 followed by 4 idle cycles (din_valid=0), then bit 0:
   - detect stays high through all idle cycles.
   - After bit 0, state = 2 and detect = 0.
4. cfg_load with pattern 8'b1101_0010, len 8, then that byte streamed MSB first:
   - detect is high after the 8th bit.
   - A subsequent cfg_load with len 9 gives a cfg_err pulse and the config is unchanged.
5. Defaults, bits 1,0, then rst low mid-cycle:
   - state_o = 0 and detect = 0 immediately.
   - After release, bit 1 gives state 1 and no detect.
6. Build with CNT_W=2, SEQDET_COUNT_EN defined, and 5 overlapping matches:
   - match_count = 3 (saturated).
   - Repeat without the macro: match_count remains 0 throughout.
